// File: rtl/apb2_bldc_multi_regs.sv
`timescale 1ns/1ps
// APB2 register front-end for num_ch BLDC driver channels: shadow/active register sets with
// atomic commit, byte strobes, pslverr on bad accesses and a per-channel commit watchdog.
module apb2_bldc_multi_regs #(
    parameter int unsigned data_width    = 32,
    parameter int unsigned addr_width    = 8,
    parameter int unsigned num_ch        = 4,
    parameter int unsigned wdog_prescale = 54000
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [addr_width-1:0] paddr,
    input  logic [data_width-1:0] pwdata,
    input  logic [3:0]            pstrb,
    output logic [data_width-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [num_ch*32-1:0]  status_in,
    input  logic [num_ch*32-1:0]  enc_counter,
    input  logic [num_ch*32-1:0]  rpm,
    output logic [num_ch-1:0]     ctrl_enable,
    output logic [num_ch*2-1:0]   ctrl_dir,
    output logic [num_ch-1:0]     ctrl_invert,
    output logic [num_ch*16-1:0]  pwm_duty,
    output logic [num_ch*16-1:0]  pwm_cycle_ticks,
    output logic [num_ch*32-1:0]  target_pos,
    output logic [num_ch-1:0]     commit_pulse,
    output logic [num_ch-1:0]     wdog_trip
);

    localparam int unsigned ChW  = addr_width - 5;
    localparam int unsigned PreW = (wdog_prescale > 1) ? $clog2(wdog_prescale) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(wdog_prescale - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e state_q;

    logic [ChW-1:0]        ch_idx;
    logic [2:0]            off;
    logic [num_ch-1:0]     hit;
    logic                  bad;
    logic                  wr_ok;
    logic [data_width-1:0] rd_data;
    logic [num_ch-1:0]     wr_ch;
    logic [num_ch-1:0]     commit;
    logic [num_ch-1:0]     wd_wr;
    logic [num_ch-1:0]     tick;
    logic [num_ch-1:0]     expire;
    logic [15:0]           to_new [num_ch];

    logic [3:0]      sh_ctrl_q [num_ch];
    logic [31:0]     sh_pwm_q  [num_ch];
    logic [31:0]     sh_tgt_q  [num_ch];
    logic [15:0]     to_q      [num_ch];
    logic [15:0]     cnt_q     [num_ch];
    logic [PreW-1:0] pre_q     [num_ch];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign ch_idx = paddr[addr_width-1:5];
    assign off    = paddr[4:2];

    always_comb begin
        hit     = '0;
        rd_data = '0;
        wr_ch   = '0;
        commit  = '0;
        wd_wr   = '0;
        tick    = '0;
        expire  = '0;
        for (int unsigned i = 0; i < num_ch; i++) begin
            if (ch_idx == ChW'(i)) hit[i] = 1'b1;
        end
        bad   = (paddr[1:0] != 2'b00) || (hit == '0) || (pwrite && (off <= 3'd2));
        wr_ok = (state_q == StAccess) && psel && penable && pwrite && !bad;
        for (int unsigned i = 0; i < num_ch; i++) begin
            wr_ch[i]  = wr_ok && hit[i];
            commit[i] = wr_ch[i] && (off == 3'd6) && pstrb[0] && pwdata[0];
            wd_wr[i]  = wr_ch[i] && (off == 3'd7);
            to_new[i] = to_q[i];
            if (wd_wr[i] && pstrb[0]) to_new[i][7:0]  = pwdata[7:0];
            if (wd_wr[i] && pstrb[1]) to_new[i][15:8] = pwdata[15:8];
            tick[i]   = (cnt_q[i] != 16'd0) && (pre_q[i] == PreMax);
            // A reload in the same cycle as expiry wins: no trip, no forced disable.
            expire[i] = tick[i] && (cnt_q[i] == 16'd1) && !commit[i] && !wd_wr[i];
            if (hit[i]) begin
                case (off)
                    3'd0:    rd_data = status_in[i*32 +: 32];
                    3'd1:    rd_data = enc_counter[i*32 +: 32];
                    3'd2:    rd_data = rpm[i*32 +: 32];
                    3'd3:    rd_data = {28'd0, sh_ctrl_q[i]};
                    3'd4:    rd_data = sh_pwm_q[i];
                    3'd5:    rd_data = sh_tgt_q[i];
                    3'd7:    rd_data = {wdog_trip[i], 15'd0, to_q[i]};
                    default: rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= StIdle;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            case (state_q)
                StIdle: begin
                    if (psel && !penable) state_q <= StAccess;
                end
                StAccess: begin
                    if (!psel) begin
                        state_q <= StIdle;
                    end else if (penable) begin
                        state_q <= StDone;
                        pready  <= 1'b1;
                        pslverr <= bad;
                        prdata  <= (pwrite || bad) ? '0 : rd_data;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned i = 0; i < num_ch; i++) begin
                sh_ctrl_q[i] <= '0;
                sh_pwm_q[i]  <= '0;
                sh_tgt_q[i]  <= '0;
                to_q[i]      <= '0;
                cnt_q[i]     <= '0;
                pre_q[i]     <= '0;
            end
            ctrl_enable     <= '0;
            ctrl_dir        <= '0;
            ctrl_invert     <= '0;
            pwm_duty        <= '0;
            pwm_cycle_ticks <= '0;
            target_pos      <= '0;
            commit_pulse    <= '0;
            wdog_trip       <= '0;
        end else begin
            commit_pulse <= commit;
            for (int unsigned i = 0; i < num_ch; i++) begin
                if (wr_ch[i] && (off == 3'd3) && pstrb[0]) sh_ctrl_q[i] <= pwdata[3:0];
                if (wr_ch[i] && (off == 3'd4)) sh_pwm_q[i] <= merge_lanes(sh_pwm_q[i], pwdata, pstrb);
                if (wr_ch[i] && (off == 3'd5)) sh_tgt_q[i] <= merge_lanes(sh_tgt_q[i], pwdata, pstrb);
                if (wd_wr[i]) to_q[i] <= to_new[i];

                if (commit[i] || wd_wr[i]) begin
                    cnt_q[i] <= to_new[i];
                    pre_q[i] <= '0;
                end else if (cnt_q[i] != 16'd0) begin
                    if (tick[i]) begin
                        pre_q[i] <= '0;
                        cnt_q[i] <= cnt_q[i] - 16'd1;
                    end else begin
                        pre_q[i] <= pre_q[i] + PreW'(1);
                    end
                end

                if (commit[i]) begin
                    ctrl_enable[i]           <= sh_ctrl_q[i][0];
                    ctrl_dir[i*2 +: 2]       <= sh_ctrl_q[i][0] ? sh_ctrl_q[i][2:1] : 2'b00;
                    ctrl_invert[i]           <= sh_ctrl_q[i][3];
                    pwm_duty[i*16 +: 16]     <= sh_pwm_q[i][15:0];
                    pwm_cycle_ticks[i*16 +: 16] <= sh_pwm_q[i][31:16];
                    target_pos[i*32 +: 32]   <= sh_tgt_q[i];
                end else if (expire[i]) begin
                    ctrl_enable[i]     <= 1'b0;
                    ctrl_dir[i*2 +: 2] <= 2'b00;
                end

                if (expire[i]) begin
                    wdog_trip[i] <= 1'b1;
                end else if (wd_wr[i] && pstrb[3] && pwdata[31]) begin
                    wdog_trip[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb2_bldc_multi_regs.sv
`timescale 1ns/1ps
// Directed bench for apb2_bldc_multi_regs: APB timing, strobes, errors, commit and watchdog.
module tb_apb2_bldc_multi_regs;

    localparam int unsigned P = 10;

    logic         pclk = 1'b0;
    logic         preset = 1'b1;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [7:0]   paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [127:0] status_in   = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};
    logic [127:0] enc_counter = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    logic [127:0] rpm         = {32'h0000_0F03, 32'h0000_0F02, 32'h0000_0F01, 32'h0000_0F00};
    logic [3:0]   ctrl_enable;
    logic [7:0]   ctrl_dir;
    logic [3:0]   ctrl_invert;
    logic [63:0]  pwm_duty;
    logic [63:0]  pwm_cycle_ticks;
    logic [127:0] target_pos;
    logic [3:0]   commit_pulse;
    logic [3:0]   wdog_trip;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  cp;
    int          ea;
    int          e0;
    int          e1;

    apb2_bldc_multi_regs #(
        .data_width   (32),
        .addr_width   (8),
        .num_ch       (4),
        .wdog_prescale(P)
    ) dut (
        .pclk           (pclk),
        .preset         (preset),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .pstrb          (pstrb),
        .prdata         (prdata),
        .pready         (pready),
        .pslverr        (pslverr),
        .status_in      (status_in),
        .enc_counter    (enc_counter),
        .rpm            (rpm),
        .ctrl_enable    (ctrl_enable),
        .ctrl_dir       (ctrl_dir),
        .ctrl_invert    (ctrl_invert),
        .pwm_duty       (pwm_duty),
        .pwm_cycle_ticks(pwm_cycle_ticks),
        .target_pos     (target_pos),
        .commit_pulse   (commit_pulse),
        .wdog_trip      (wdog_trip)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transfer; ACCESS edge lands two posedges after a call made just past a posedge.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
        int n;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        penable = 1'b1;
        n = 0;
        do begin
            @(posedge pclk); #1;
            n++;
        end while (!pready && n < 8);
        check("pready", pready, 1);
        rd = prdata; err = pslverr; cp = commit_pulse; ea = cyc;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        apb(1'b1, addr, data, strb);
        check("wr_slverr", err, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        apb(1'b0, addr, 32'h0, 4'h0);
        check(tag, rd, exp);
        check("rd_slverr", err, 0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge pclk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", pready, 0);
        check("rst_prdata", prdata, 0);
        check("rst_en", ctrl_enable, 0);
        check("rst_dir", ctrl_dir, 0);
        check("rst_duty", pwm_duty, 0);
        check("rst_trip", wdog_trip, 0);
        @(negedge pclk);
        preset = 1'b0;

        // ch1 shadow then commit
        wr(8'h2C, 32'h0000_0005, 4'hF);
        wr(8'h30, 32'h0100_0080, 4'hF);
        check("pre_commit_en", ctrl_enable, 0);
        check("pre_commit_duty", pwm_duty, 0);
        rd_chk("ch1_ctrl_rb", 8'h2C, 32'h5);
        wr(8'h38, 32'h1, 4'hF);
        check("commit_pulse", cp, 4'b0010);
        check("pulse_clear", commit_pulse, 4'b0000);
        check("ch1_en", ctrl_enable, 4'b0010);
        check("ch1_dir", ctrl_dir, 8'h08);
        check("ch1_duty", pwm_duty, 64'h0000_0000_0080_0000);
        check("ch1_cycle", pwm_cycle_ticks, 64'h0000_0000_0100_0000);

        // ch3 commit with en=0 forces dir to none
        wr(8'h6C, 32'h0000_0006, 4'hF);
        wr(8'h78, 32'h1, 4'hF);
        check("ch3_en", ctrl_enable, 4'b0010);
        check("ch3_dir_forced", ctrl_dir, 8'h08);

        wr(8'h14, 32'hAABB_CCDD, 4'b0010);
        rd_chk("tgt_strb", 8'h14, 32'h0000_CC00);
        check("tgt_active", target_pos[31:0], 0);

        apb(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF);
        check("wr_status_err", err, 1);
        rd_chk("status_ch0", 8'h00, 32'h1234_5678);
        rd_chk("rpm_ch3", 8'h68, 32'h0000_0F03);
        apb(1'b0, 8'h82, 32'h0, 4'hF);
        check("rd_82_err", err, 1);
        check("rd_82_prdata", rd, 0);
        apb(1'b1, 8'h0D, 32'h0000_000F, 4'hF);
        check("misaligned_err", err, 1);
        apb(1'b1, 8'h8C, 32'h0000_000F, 4'hF);
        check("ch4_err", err, 1);
        rd_chk("ctrl_after_bad", 8'h0C, 32'h0);
        rd_chk("commit_reads_0", 8'h38, 32'h0);

        // setup then psel dropped in ACCESS
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hF; pstrb = 4'hF;
        @(negedge pclk);
        psel = 1'b0; pwrite = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            check("abort_pready", pready, 0);
            check("abort_prdata", prdata, 0);
        end
        rd_chk("ctrl_after_abort", 8'h0C, 32'h0);

        // ch2 watchdog expiry
        wr(8'h5C, 32'h0000_0003, 4'hF);
        wr(8'h4C, 32'h0000_0003, 4'hF);
        wr(8'h58, 32'h1, 4'hF);
        e0 = ea;
        check("wd_en", ctrl_enable, 4'b0110);
        check("wd_dir", ctrl_dir, 8'h18);
        wait_cyc(e0 + 3 * P - 1);
        check("wd_before_en", ctrl_enable, 4'b0110);
        check("wd_before_trip", wdog_trip, 4'b0000);
        wait_cyc(e0 + 3 * P);
        check("wd_drop_en", ctrl_enable, 4'b0010);
        check("wd_drop_dir", ctrl_dir, 8'h08);
        check("wd_trip", wdog_trip, 4'b0100);
        rd_chk("wd_rb", 8'h5C, 32'h8000_0003);
        rd_chk("wd_shadow_kept", 8'h4C, 32'h3);
        wr(8'h58, 32'h1, 4'hF);
        check("tripped_commit_en", ctrl_enable, 4'b0110);
        check("tripped_commit_trip", wdog_trip, 4'b0100);
        wr(8'h5C, 32'h8000_0000, 4'hF);
        check("trip_w1c", wdog_trip, 4'b0000);
        rd_chk("wd_rb_clear", 8'h5C, 32'h0);

        // commit lands on the expiry edge
        wr(8'h5C, 32'h0000_0003, 4'hF);
        wr(8'h58, 32'h1, 4'hF);
        e1 = ea;
        wait_cyc(e1 + 3 * P - 2);
        wr(8'h58, 32'h1, 4'hF);
        check("coinc_pulse", cp, 4'b0100);
        check("coinc_en", ctrl_enable, 4'b0110);
        check("coinc_trip", wdog_trip, 4'b0000);
        wr(8'h5C, 32'h0, 4'hF);
        check("coinc_trip_later", wdog_trip, 4'b0000);

        // async reset during ACCESS
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h2C;
        @(negedge pclk);
        penable = 1'b1;
        preset = 1'b1;
        @(posedge pclk); #1;
        check("midrst_pready", pready, 0);
        check("midrst_prdata", prdata, 0);
        check("midrst_en", ctrl_enable, 0);
        check("midrst_dir", ctrl_dir, 0);
        check("midrst_duty", pwm_duty, 0);
        check("midrst_cycle", pwm_cycle_ticks, 0);
        check("midrst_tgt", target_pos[63:0], 0);
        check("midrst_pulse", commit_pulse, 0);
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        rd_chk("ch1_ctrl_after_rst", 8'h2C, 32'h0);
        rd_chk("ch1_pwm_after_rst", 8'h30, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
